rr_arbiter_4: RTL



---
 rtl/rr_arbiter_4_pkg.sv | 17 +
 rtl/rr_arbiter_4_if.sv | 22 ++
 rtl/rr_arbiter_4_pick.sv | 30 +++
 rtl/rr_arbiter_4.sv | 101 ++++++++++
 4 files changed

// File: rtl/rr_arbiter_4_pkg.sv
// Shared definitions for the four-requester round-robin arbiter:
// FSM state encodings, requester count, index width and a one-hot helper.
package rr_arbiter_4_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  function automatic logic [NUM_REQ-1:0] idx2onehot(input logic [IDX_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_arbiter_4_if.sv
// Request/grant bundle between the requesting agents (master) and the arbiter (slave).
interface rr_arbiter_4_if;
  import rr_arbiter_4_pkg::*;

  logic               en;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_valid;
  logic               timeout;

  modport master (
    output en, req,
    input  gnt, gnt_idx, gnt_valid, timeout
  );

  modport slave (
    input  en, req,
    output gnt, gnt_idx, gnt_valid, timeout
  );

endinterface

// File: rtl/rr_arbiter_4_pick.sv
// Combinational rotating-priority picker: the first set request at or after ptr
// (modulo 4) wins.
module rr_pick_4
  import rr_arbiter_4_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               any,
  output logic [IDX_W-1:0]   idx
);

  logic [NUM_REQ-1:0] rot;
  logic [IDX_W-1:0]   enc;

  // Rotate so ptr lands on bit 0, fixed-priority encode, then undo the rotation.
  always_comb begin
    rot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rot[i] = req[IDX_W'(i) + ptr];
    end
    enc = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) enc = IDX_W'(i);
    end
  end

  assign any = |rot;
  assign idx = enc + ptr;

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with registered one-hot grant, encoded index
// and a bounded hold time that forcibly revokes a grant after MAX_HOLD cycles.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | no grant held; picks the next owner when en=1 and req!=0
//   ST_GRANT | gnt_idx owns the resource; ends on release or hold timeout
module rr_arbiter_4
  import rr_arbiter_4_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
)(
  input  logic          clk,
  input  logic          rst_n,
  rr_arbiter_4_if.slave bus
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_e             state_q,    state_d;
  logic [IDX_W-1:0]   ptr_q,      ptr_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [NUM_REQ-1:0] gnt_q,      gnt_d;
  logic [IDX_W-1:0]   gnt_idx_q,  gnt_idx_d;
  logic               timeout_q,  timeout_d;

  logic               pick_any;
  logic [IDX_W-1:0]   pick_idx;

  rr_pick_4 u_pick (
    .req (bus.req),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    gnt_d      = gnt_q;
    gnt_idx_d  = gnt_idx_q;
    timeout_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.en && pick_any) begin
          state_d    = ST_GRANT;
          gnt_d      = idx2onehot(pick_idx);
          gnt_idx_d  = pick_idx;
          hold_cnt_d = '0;
        end
      end
      ST_GRANT: begin
        // Owner done or out of hold budget: priority moves past the owner.
        if (!bus.req[gnt_idx_q]) begin
          state_d    = ST_IDLE;
          gnt_d      = '0;
          hold_cnt_d = '0;
          ptr_d      = gnt_idx_q + IDX_W'(1);
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d    = ST_IDLE;
          gnt_d      = '0;
          hold_cnt_d = '0;
          timeout_d  = 1'b1;
          ptr_d      = gnt_idx_q + IDX_W'(1);
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      gnt_q      <= '0;
      gnt_idx_q  <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_q      <= gnt_d;
      gnt_idx_q  <= gnt_idx_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = gnt_idx_q;
  assign bus.gnt_valid = |gnt_q;
  assign bus.timeout   = timeout_q;

endmodule
